mux: RTL and testbench

MUX -- requirements
Module: mux

---
 rtl/mux.sv | 61 ++++++
 tb/tb_mux.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mux.sv
// 4:1 data mux on select {r,s}, with a registered one-cycle pulse on every select change.
// Define MUX_OUT_REG_EN to register y (1-cycle latency, synchronous reset to 0).
module mux #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             r,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    output logic             sel_chg
);

    localparam int unsigned SEL_W = 2;

    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_prev;
    logic [WIDTH-1:0] y_sel;

    assign sel = {r, s};

    // Flat decode; an unknown select falls to the default and yields all-X.
    always_comb begin
        y_sel = 'x;
        case (sel)
            2'b00:   y_sel = a;
            2'b01:   y_sel = b;
            2'b10:   y_sel = c;
            2'b11:   y_sel = d;
            default: y_sel = 'x;
        endcase
    end

`ifdef MUX_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= WIDTH'(0);
        end else begin
            y <= y_sel;
        end
    end
`else
    assign y = y_sel;
`endif

    // Select history; reset wins over any same-cycle change.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_prev <= SEL_W'(0);
            sel_chg  <= 1'b0;
        end else begin
            sel_prev <= sel;
            sel_chg  <= (sel != sel_prev);
        end
    end

endmodule

// File: tb/tb_mux.sv
// Scoreboard bench for mux: stimulus pushes expectations, monitors pop and compare.
module tb_mux;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a, b, c, d;
    logic         r, s;
    logic [W-1:0] y;
    logic         sel_chg;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] exp_y_q[$];
    logic         exp_chg_q[$];
    logic [1:0]   m_prev;

    mux #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .r       (r),
        .s       (s),
        .y       (y),
        .sel_chg (sel_chg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the falling edge and record what the DUT owes.
    task automatic step(input bit rv, input logic [1:0] sv,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] cv, input logic [W-1:0] dv);
        logic [W-1:0] data [4];
        @(negedge clk);
        rst = rv;
        {r, s} = sv;
        a = av; b = bv; c = cv; d = dv;
        data[0] = av; data[1] = bv; data[2] = cv; data[3] = dv;
`ifdef MUX_OUT_REG_EN
        exp_y_q.push_back(rv ? W'(0) : data[sv]);
`else
        exp_y_q.push_back(data[sv]);
`endif
        exp_chg_q.push_back(rv ? 1'b0 : (sv != m_prev));
        m_prev = rv ? 2'b00 : sv;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

`ifdef MUX_OUT_REG_EN
    // Registered y is due just after the edge that loads it.
    initial forever begin
        @(posedge clk); #1;
        if (exp_y_q.size() > 0) check("y_reg", y, exp_y_q.pop_front());
    end
`else
    // Combinational y is due in the same cycle the inputs were applied.
    initial forever begin
        @(negedge clk); #1;
        if (exp_y_q.size() > 0) check("y_comb", y, exp_y_q.pop_front());
    end
`endif

    initial forever begin
        @(posedge clk); #1;
        if (exp_chg_q.size() > 0) check("sel_chg", W'(sel_chg), W'(exp_chg_q.pop_front()));
    end

    initial begin
        m_prev = 2'b00;
        rst = 1'b1; r = 1'b0; s = 1'b0;
        a = '0; b = '0; c = '0; d = '0;

        // Reset for two cycles, then hold select 10: exactly one pulse.
        step(1, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44);
        step(1, 2'b01, 8'h11, 8'h22, 8'h33, 8'h44);
        for (int i = 0; i < 3; i++) step(0, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44);

        // All inputs one, select stepped through every code.
        step(1, 2'b00, 8'h01, 8'h01, 8'h01, 8'h01);
        for (int i = 0; i < 4; i++) step(0, 2'(i), 8'h01, 8'h01, 8'h01, 8'h01);

        // One-hot inputs, select stepped 00..11 after reset.
        step(1, 2'b00, 8'h01, 8'h02, 8'h04, 8'h08);
        for (int i = 0; i < 4; i++) step(0, 2'(i), 8'h01, 8'h02, 8'h04, 8'h08);

        // Back-to-back toggles, then data-only changes.
        step(0, 2'b01, 8'h01, 8'h02, 8'h04, 8'h08);
        step(0, 2'b10, 8'h01, 8'h02, 8'h04, 8'h08);
        step(0, 2'b01, 8'h01, 8'h02, 8'h04, 8'h08);
        for (int i = 0; i < 4; i++)
            step(0, 2'b01, W'($urandom), W'($urandom), W'($urandom), W'($urandom));

        // Reset coinciding with a select change, then hold that select.
        step(1, 2'b11, 8'hA0, 8'hB0, 8'hC0, 8'hD0);
        step(0, 2'b11, 8'hA0, 8'hB0, 8'hC0, 8'hD0);
        step(0, 2'b11, 8'hA0, 8'hB0, 8'hC0, 8'hD0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
                 W'($urandom), W'($urandom), W'($urandom), W'($urandom));

        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (exp_y_q.size() != 0 || exp_chg_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_y_q.size(), exp_chg_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
